// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the cell-array FIFO controllers.
package fifo_pkg;
  localparam int N_CELLS_DEF = 16;
  localparam int DATA_W_DEF = 8;
  typedef logic [N_CELLS_DEF-1:0] cell_vec_t;
  localparam cell_vec_t TOKEN_RST = cell_vec_t'(1);
endpackage

// File: rtl/full_detector.sv
// full_detector: registered anticipating full flag, set when no two ring-adjacent cells are both empty.
module full_detector #(
  parameter int N_CELLS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CELLS-1:0] f_i,
  output logic               full
);
  logic [N_CELLS-1:0] pair_ok;
  logic full_next;
  always_comb begin
    pair_ok = f_i | {f_i[0], f_i[N_CELLS-1:1]};
    full_next = &pair_ok;
  end
  always_ff @(posedge clk)
    full <= reset ? 1'b0 : full_next;
endmodule

// File: rtl/fifo_put_controller.sv
// fifo_put_controller: put-side token ring, write gating, overflow flag; PUT_ALMOST_FULL_EN adds almost_full.
module fifo_put_controller
  import fifo_pkg::*;
#(
  parameter int N_CELLS = N_CELLS_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef PUT_ALMOST_FULL_EN
  , parameter int AF_MARGIN = 2
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_put,
  input  logic [DATA_W-1:0]  data_put,
  input  logic [N_CELLS-1:0] f_i,
  output logic [N_CELLS-1:0] we_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               full,
  output logic               put_ack,
  output logic               ovf_err
`ifdef PUT_ALMOST_FULL_EN
  , output logic             almost_full
`endif
);
  logic [N_CELLS-1:0] token;
  logic en_put;
  full_detector #(.N_CELLS(N_CELLS)) u_full (
    .clk(clk),
    .reset(reset),
    .f_i(f_i),
    .full(full)
  );
  always_comb begin
    en_put = req_put & ~full & ~reset;
    put_ack = en_put;
    we_o = token & {N_CELLS{en_put}};
    data_o = data_put;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      token <= N_CELLS'(TOKEN_RST);
      ovf_err <= 1'b0;
    end else if (en_put) begin
      token <= {token[N_CELLS-2:0], token[N_CELLS-1]};
      ovf_err <= ovf_err | (|(token & f_i));
    end
  end
`ifdef PUT_ALMOST_FULL_EN
  always_ff @(posedge clk)
    almost_full <= reset ? 1'b0 : ($countones(f_i) >= N_CELLS - AF_MARGIN);
`endif
endmodule

// File: tb/tb_fifo_put_controller.sv
// tb_fifo_put_controller: scoreboard bench against an index-based reference model of the put controller.
module tb_fifo_put_controller;
  localparam int N = 16;
  localparam int W = 8;
  logic clk = 0;
  logic reset = 1;
  logic req_put = 0;
  logic [W-1:0] data_put = 0;
  logic [N-1:0] f_i = 0;
  logic [N-1:0] we_o;
  logic [W-1:0] data_o;
  logic full, put_ack, ovf_err;
`ifdef PUT_ALMOST_FULL_EN
  logic almost_full;
`endif
  fifo_put_controller #(.N_CELLS(N), .DATA_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .req_put(req_put),
    .data_put(data_put),
    .f_i(f_i),
    .we_o(we_o),
    .data_o(data_o),
    .full(full),
    .put_ack(put_ack),
    .ovf_err(ovf_err)
`ifdef PUT_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] we;
    logic [W-1:0] data;
    logic ack, full, ovf, af;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int ptr = 0;
  bit m_full = 0, m_ovf = 0, m_af = 0;

  function automatic bit ring_full(input logic [N-1:0] f);
    for (int i = 0; i < N; i++)
      if (!f[i] && !f[(i + 1) % N]) return 0;
    return 1;
  endfunction

  task automatic cyc(input bit r, input bit rs, input bit setbit);
    exp_t e;
    bit en;
    int p;
    req_put = r;
    reset = rs;
    data_put = W'($urandom);
    en = r && !m_full && !rs;
    e.we = en ? N'(1) << ptr : '0;
    e.data = data_put;
    e.ack = en;
    e.full = m_full;
    e.ovf = m_ovf;
    e.af = m_af;
    q.push_back(e);
    @(posedge clk);
    p = ptr;
    if (rs) begin
      ptr = 0;
      m_full = 0;
      m_ovf = 0;
      m_af = 0;
    end else begin
      if (en) begin
        if (f_i[ptr]) m_ovf = 1;
        ptr = (ptr + 1) % N;
      end
      m_full = ring_full(f_i);
      m_af = $countones(f_i) >= N - 2;
    end
    #1;
    if (setbit && en) f_i[p] = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic a;
    if (q.size() != 0) begin
      e = q.pop_front();
`ifdef PUT_ALMOST_FULL_EN
      a = almost_full;
`else
      a = e.af;
`endif
      tests++;
      if (we_o !== e.we || put_ack !== e.ack || full !== e.full || ovf_err !== e.ovf || data_o !== e.data || a !== e.af) begin
        fails++;
        $display("FAIL cycle t=%0t: we_o=%h ack=%b full=%b ovf=%b data=%h af=%b, want we_o=%h ack=%b full=%b ovf=%b data=%h af=%b",
                 $time, we_o, put_ack, full, ovf_err, data_o, a, e.we, e.ack, e.full, e.ovf, e.data, e.af);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    f_i = '0;
    for (int i = 0; i < 22; i++) cyc(1, 0, 1);
    f_i = ~16'h0088;
    cyc(0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0);
    f_i[4] = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    f_i = '0;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    f_i = ~16'h0018;
    f_i[ptr] = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    f_i = '0;
    for (int i = 0; i < 4; i++) cyc($urandom_range(0, 1) == 1, 0, 0);
    for (int i = 0; i < 20 && ptr != 9; i++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    f_i = 16'h1fff;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    f_i = 16'h3fff;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    f_i = 16'h1fff;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      f_i = N'($urandom) | N'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 0);
    end
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
